fm_spy_buffer_pb: RTL and testbench
===================================

Name: fm_spy_buffer_pb

Overview:
- Parametrised fast-monitoring spy buffer with playback, successor to the fixed per-link SB instances in the FM spy-buffer set.
- Captures one monitored stream (fm_data/fm_vld, up to mon_dw_max bits) into a DEPTH-entry circular memory.
- Supports free-run spy, trigger-and-freeze with a programmable post-trigger count, and one-shot or looped playback.
- Exposes a 32-bit word-addressed AXI-side read/write port for readout and for playback loading.

Parameters:
- DATA_WIDTH, 256: monitored data width, 1..mon_dw_max.
- AXI_DW, 32: AXI word width.
- DEPTH, 1024: entries; power of 2, at least 4.
- WORDS, find_ceil(DATA_WIDTH, AXI_DW): AXI words per entry, i.e. ceil(DATA_WIDTH/AXI_DW), rounded up to even when >1.
- AW, $clog2(DEPTH): entry pointer width.
- WW, max(1, $clog2(WORDS)): word-select width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- pb_mode  in  2  00 spy, 01 trigger-freeze, 10 playback once, 11 playback loop
- freeze  in  1  level; stop capture / pause playback
- trigger  in  1  pulse; mode 01 trigger
- rearm  in  1  pulse; leave FROZEN/PB_DONE
- post_trig_cnt  in  AW  samples written after the trigger sample
- pb_len  in  AW+1  playback entries, 0..DEPTH
- in_data  in  DATA_WIDTH  monitored data
- in_vld  in  1  monitored valid
- out_data  out  DATA_WIDTH  playback data
- out_vld  out  1  playback valid
- axi_rd_en  in  1  read request
- axi_rd_addr  in  AW+WW  {entry, word}
- axi_rd_data  out  AXI_DW  read data
- axi_rd_vld  out  1  read data valid
- axi_wr_en  in  1  write request
- axi_wr_addr  in  AW+WW  {entry, word}
- axi_wr_data  in  AXI_DW  write data
- wr_err  out  1  one-cycle pulse: write rejected
- frozen  out  1  state is FROZEN
- wr_ptr  out  AW  next capture entry
- trig_ptr  out  AW  entry holding the trigger-cycle position
- wrapped  out  1  capture has wrapped at least once

Behaviour:
- Reset: state SPY; all outputs 0; rd_ptr 0; post counter 0.
- States: SPY, POST, FROZEN, PLAYBACK, PB_DONE.
- pb_mode is sampled every cycle.
  - A change into 1x from any state: PLAYBACK, rd_ptr=0.
  - A change from 1x to 0x: SPY, wr_ptr=0, wrapped=0.
- SPY:
  - Each cycle with in_vld=1 and freeze=0: mem[wr_ptr]=in_data (zero-padded), wr_ptr++ mod DEPTH.
  - The DEPTH-1 to 0 wrap sets wrapped (sticky).
  - freeze=1 moves to FROZEN; a sample in the same cycle as freeze is not written.
  - In mode 01, trigger=1 (freeze=0):
    - the trigger-cycle sample is written if in_vld;
    - trig_ptr = wr_ptr before the increment;
    - cnt = post_trig_cnt.
    - If post_trig_cnt=0, go to FROZEN next cycle; otherwise go to POST.
  - trigger is ignored in mode 00.
- POST:
  - Capture as in SPY.
  - Each write decrements cnt; the write that makes cnt 0 moves to FROZEN.
  - freeze=1 moves to FROZEN immediately.
  - A further trigger is ignored.
- FROZEN: no captures; frozen=1. rearm with freeze=0 moves to SPY with wr_ptr=0, wrapped=0. rearm with freeze=1 is ignored.
- PLAYBACK:
  - Synchronous memory read, 1-cycle latency.
  - out_vld=1 and out_data=mem[rd_ptr] one cycle after each read issue, so the first out_vld is on the 2nd cycle after pb_mode becomes 1x.
  - rd_ptr advances one per cycle while freeze=0. freeze=1 holds rd_ptr, and out_vld=0 from the next cycle.
  - Mode 10: after entry pb_len-1, go to PB_DONE.
  - Mode 11: wrap to 0, continuous.
  - pb_len=0: no out_vld; mode 10 goes to PB_DONE immediately, mode 11 idles in PLAYBACK.
  - pb_len>DEPTH is clamped to DEPTH.
- PB_DONE: out_vld=0; rearm restarts PLAYBACK at rd_ptr=0.
- AXI read:
  - Allowed in all states.
  - axi_rd_vld and axi_rd_data arrive 2 cycles after axi_rd_en; back-to-back every cycle.
  - Word w maps to entry bits [w*AXI_DW +: AXI_DW].
  - Padding bits at or above DATA_WIDTH, and word index >= WORDS, read 0.
- AXI write:
  - Accepted only in FROZEN, PLAYBACK and PB_DONE; updates one word only.
  - In SPY/POST the write is dropped and wr_err=1 on the next cycle.
  - Padding bits are discarded.
  - A same-cycle write and playback read of the same entry returns the old data (read-first).
- rst mid-operation: returns to reset values next cycle; memory contents are not cleared.

Test Plan:
- DATA_WIDTH=96, DEPTH=16, mode 00: write 20 samples with value i -> wr_ptr=4, wrapped=1; AXI read of entry 3 word 0 returns 19, word 3 returns 0, with axi_rd_vld 2 cycles after axi_rd_en.
- Mode 01, post_trig_cnt=3: trigger on the sample 5 cycle -> trig_ptr=5; samples 6, 7, 8 written; FROZEN after 8, wr_ptr=9, frozen=1; later in_vld causes no change; rearm -> wr_ptr=0, wrapped=0.
- Mode 01, post_trig_cnt=0, trigger with in_vld=1 -> only the trigger sample written; frozen=1 the next cycle.
- FROZEN: load entries 0..3 via AXI writes, set pb_len=4, mode 10 -> out_vld on cycles 2..5 with entries 0..3, then PB_DONE; rearm replays; mode 11 repeats 0,1,2,3,0,... with a freeze pulse holding the sequence.
- Mode 00: AXI write -> wr_err pulse, memory unchanged; freeze and in_vld in the same cycle -> sample not stored.
- rst asserted mid-PLAYBACK -> out_vld=0 next cycle, state SPY, previously captured data still readable via AXI.

Source files
------------

// File: rtl/fm_spy_buffer_pb.sv
`default_nettype none
// ============================================================================
//  Module   : fm_spy_buffer_pb
//  Function : Fast-monitoring spy buffer. Captures one monitored stream into a
//             circular memory (free-run or trigger-and-freeze) and can play the
//             memory back once or in a loop. A word-addressed AXI-side port
//             reads the buffer at any time and loads it for playback.
//  Revision : 1.0  initial release
// ============================================================================
module fm_spy_buffer_pb #(
    parameter int DATA_WIDTH = 256,
    parameter int AXI_DW     = 32,
    parameter int DEPTH      = 1024,
    localparam int WORDS_RAW = (DATA_WIDTH + AXI_DW - 1) / AXI_DW,
    localparam int WORDS     = (WORDS_RAW > 1) ? (WORDS_RAW + (WORDS_RAW % 2)) : 1,
    localparam int AW        = $clog2(DEPTH),
    localparam int WW        = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            pb_mode,
    input  logic                  freeze,
    input  logic                  trigger,
    input  logic                  rearm,
    input  logic [AW-1:0]         post_trig_cnt,
    input  logic [AW:0]           pb_len,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_vld,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_vld,
    input  logic                  axi_rd_en,
    input  logic [AW+WW-1:0]      axi_rd_addr,
    output logic [AXI_DW-1:0]     axi_rd_data,
    output logic                  axi_rd_vld,
    input  logic                  axi_wr_en,
    input  logic [AW+WW-1:0]      axi_wr_addr,
    input  logic [AXI_DW-1:0]     axi_wr_data,
    output logic                  wr_err,
    output logic                  frozen,
    output logic [AW-1:0]         wr_ptr,
    output logic [AW-1:0]         trig_ptr,
    output logic                  wrapped
);

    // Entries are stored padded to a whole number of AXI words; the padding
    // bits are always written as zero so they read back as zero.
    localparam int             MW           = WORDS * AXI_DW;
    localparam logic [MW:0]    c_ONE        = {{MW{1'b0}}, 1'b1};
    localparam logic [MW-1:0]  c_VALID_MASK = MW'((c_ONE << DATA_WIDTH) - c_ONE);
    localparam logic [AW:0]    c_DEPTH_L    = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_SPY      = 3'd0,
        S_POST     = 3'd1,
        S_FROZEN   = 3'd2,
        S_PLAYBACK = 3'd3,
        S_PB_DONE  = 3'd4
    } state_t;

    state_t                r_state, w_nxt_state;
    logic [AW-1:0]         r_wr_ptr, w_nxt_wr_ptr;
    logic [AW-1:0]         r_trig_ptr, w_nxt_trig_ptr;
    logic [AW-1:0]         r_cnt, w_nxt_cnt;
    logic [AW-1:0]         r_rd_ptr, w_nxt_rd_ptr;
    logic                  r_wrapped, w_nxt_wrapped;
    logic                  r_mode_hi_q;
    logic                  w_mode_up, w_mode_down;
    logic                  w_cap_we, w_pb_issue, w_pb_last;
    logic [AW:0]           w_eff_len;
    logic [MW-1:0]         r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_vld;
    logic                  r_wr_err;
    logic                  w_axi_we;
    logic [AW-1:0]         w_axi_wr_entry;
    logic [WW-1:0]         w_axi_wr_word;
    logic [MW-1:0]         r_rd_entry;
    logic [WW-1:0]         r_rd_wsel;
    logic                  r_rd_v1;
    logic [AXI_DW-1:0]     r_axi_rd_data, w_rd_word;
    logic                  r_axi_rd_vld;

    assign w_mode_up      = pb_mode[1] & ~r_mode_hi_q;
    assign w_mode_down    = ~pb_mode[1] & r_mode_hi_q;
    assign w_eff_len      = (pb_len > c_DEPTH_L) ? c_DEPTH_L : pb_len;
    assign w_pb_last      = ({1'b0, r_rd_ptr} == (w_eff_len - (AW+1)'(1)));
    assign w_axi_wr_entry = axi_wr_addr[AW+WW-1:WW];
    assign w_axi_wr_word  = axi_wr_addr[WW-1:0];
    assign w_axi_we       = axi_wr_en & ~rst
                          & ((r_state == S_FROZEN) | (r_state == S_PLAYBACK) | (r_state == S_PB_DONE))
                          & ({1'b0, w_axi_wr_word} < (WW+1)'(WORDS));

    // Next-state, pointer and capture/playback-issue decisions
    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_wr_ptr   = r_wr_ptr;
        w_nxt_trig_ptr = r_trig_ptr;
        w_nxt_cnt      = r_cnt;
        w_nxt_rd_ptr   = r_rd_ptr;
        w_nxt_wrapped  = r_wrapped;
        w_cap_we       = 1'b0;
        w_pb_issue     = 1'b0;
        case (r_state)
            S_SPY: begin
                if (freeze) begin
                    w_nxt_state = S_FROZEN;
                end else begin
                    w_cap_we = in_vld;
                    if ((pb_mode == 2'b01) && trigger) begin
                        w_nxt_trig_ptr = r_wr_ptr;
                        w_nxt_cnt      = post_trig_cnt;
                        w_nxt_state    = (post_trig_cnt == '0) ? S_FROZEN : S_POST;
                    end
                end
            end
            S_POST: begin
                if (freeze) begin
                    w_nxt_state = S_FROZEN;
                end else if (in_vld) begin
                    w_cap_we  = 1'b1;
                    w_nxt_cnt = r_cnt - AW'(1);
                    if (r_cnt == AW'(1)) begin
                        w_nxt_state = S_FROZEN;
                    end
                end
            end
            S_FROZEN: begin
                if (rearm && !freeze) begin
                    w_nxt_state   = S_SPY;
                    w_nxt_wr_ptr  = '0;
                    w_nxt_wrapped = 1'b0;
                end
            end
            S_PLAYBACK: begin
                if (w_eff_len == '0) begin
                    if (!pb_mode[0]) begin
                        w_nxt_state = S_PB_DONE;
                    end
                end else if (!freeze) begin
                    w_pb_issue = 1'b1;
                    if (w_pb_last) begin
                        w_nxt_rd_ptr = '0;
                        if (!pb_mode[0]) begin
                            w_nxt_state = S_PB_DONE;
                        end
                    end else begin
                        w_nxt_rd_ptr = r_rd_ptr + AW'(1);
                    end
                end
            end
            S_PB_DONE: begin
                if (rearm) begin
                    w_nxt_state  = S_PLAYBACK;
                    w_nxt_rd_ptr = '0;
                end
            end
            default: w_nxt_state = S_SPY;
        endcase

        // Mode-group changes take precedence over everything the state wanted
        if (w_mode_up) begin
            w_nxt_state    = S_PLAYBACK;
            w_nxt_rd_ptr   = '0;
            w_nxt_cnt      = r_cnt;
            w_nxt_trig_ptr = r_trig_ptr;
            w_cap_we       = 1'b0;
            w_pb_issue     = 1'b0;
        end else if (w_mode_down) begin
            w_nxt_state   = S_SPY;
            w_nxt_wr_ptr  = '0;
            w_nxt_wrapped = 1'b0;
            w_cap_we      = 1'b0;
            w_pb_issue    = 1'b0;
        end

        if (w_cap_we) begin
            w_nxt_wr_ptr = r_wr_ptr + AW'(1);
            if (&r_wr_ptr) begin
                w_nxt_wrapped = 1'b1;
            end
        end
    end

    // Control registers, playback output register and write-error pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_SPY;
            r_wr_ptr    <= '0;
            r_trig_ptr  <= '0;
            r_cnt       <= '0;
            r_rd_ptr    <= '0;
            r_wrapped   <= 1'b0;
            r_mode_hi_q <= 1'b0;
            r_out_vld   <= 1'b0;
            r_out_data  <= '0;
            r_wr_err    <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_wr_ptr    <= w_nxt_wr_ptr;
            r_trig_ptr  <= w_nxt_trig_ptr;
            r_cnt       <= w_nxt_cnt;
            r_rd_ptr    <= w_nxt_rd_ptr;
            r_wrapped   <= w_nxt_wrapped;
            r_mode_hi_q <= pb_mode[1];
            r_out_vld   <= w_pb_issue;
            if (w_pb_issue) begin
                r_out_data <= r_mem[r_rd_ptr][DATA_WIDTH-1:0];
            end
            r_wr_err    <= axi_wr_en & ((r_state == S_SPY) | (r_state == S_POST));
        end
    end

    // Single write port: capture in SPY/POST, AXI word writes otherwise
    always_ff @(posedge clk) begin
        if (w_cap_we && !rst) begin
            r_mem[r_wr_ptr] <= MW'(in_data);
        end else if (w_axi_we) begin
            for (int w = 0; w < WORDS; w++) begin
                if (w_axi_wr_word == WW'(w)) begin
                    r_mem[w_axi_wr_entry][w*AXI_DW +: AXI_DW] <=
                        axi_wr_data & c_VALID_MASK[w*AXI_DW +: AXI_DW];
                end
            end
        end
    end

    // AXI read stage 1: fetch the whole entry and remember the word select
    always_ff @(posedge clk) begin
        r_rd_entry <= r_mem[axi_rd_addr[AW+WW-1:WW]];
        r_rd_wsel  <= axi_rd_addr[WW-1:0];
    end

    // Word select; indices beyond the stored words read as zero
    always_comb begin
        w_rd_word = '0;
        for (int w = 0; w < WORDS; w++) begin
            if (r_rd_wsel == WW'(w)) begin
                w_rd_word = r_rd_entry[w*AXI_DW +: AXI_DW];
            end
        end
    end

    // AXI read stage 2: registered data and valid
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_v1       <= 1'b0;
            r_axi_rd_vld  <= 1'b0;
            r_axi_rd_data <= '0;
        end else begin
            r_rd_v1       <= axi_rd_en;
            r_axi_rd_vld  <= r_rd_v1;
            r_axi_rd_data <= r_rd_v1 ? w_rd_word : '0;
        end
    end

    assign out_data    = r_out_data;
    assign out_vld     = r_out_vld;
    assign axi_rd_data = r_axi_rd_data;
    assign axi_rd_vld  = r_axi_rd_vld;
    assign wr_err      = r_wr_err;
    assign frozen      = (r_state == S_FROZEN);
    assign wr_ptr      = r_wr_ptr;
    assign trig_ptr    = r_trig_ptr;
    assign wrapped     = r_wrapped;

endmodule
`default_nettype wire

// File: tb/tb_fm_spy_buffer_pb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fm_spy_buffer_pb
//  Function : Self-checking bench for fm_spy_buffer_pb (96-bit data, 16 deep)
//  Revision : 1.0  initial release
// ============================================================================
module tb_fm_spy_buffer_pb;

    localparam int DW  = 96;
    localparam int ADW = 32;
    localparam int DEP = 16;
    localparam int AW  = 4;
    localparam int WW  = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      pb_mode = 2'b00;
    logic            freeze = 1'b0, trigger = 1'b0, rearm = 1'b0;
    logic [AW-1:0]   post_trig_cnt = '0;
    logic [AW:0]     pb_len = '0;
    logic [DW-1:0]   in_data = '0;
    logic            in_vld = 1'b0;
    logic [DW-1:0]   out_data;
    logic            out_vld;
    logic            axi_rd_en = 1'b0;
    logic [AW+WW-1:0] axi_rd_addr = '0;
    logic [ADW-1:0]  axi_rd_data;
    logic            axi_rd_vld;
    logic            axi_wr_en = 1'b0;
    logic [AW+WW-1:0] axi_wr_addr = '0;
    logic [ADW-1:0]  axi_wr_data = '0;
    logic            wr_err, frozen, wrapped;
    logic [AW-1:0]   wr_ptr, trig_ptr;

    fm_spy_buffer_pb #(.DATA_WIDTH(DW), .AXI_DW(ADW), .DEPTH(DEP)) u_dut (
        .clk(clk), .rst(rst), .pb_mode(pb_mode), .freeze(freeze), .trigger(trigger),
        .rearm(rearm), .post_trig_cnt(post_trig_cnt), .pb_len(pb_len),
        .in_data(in_data), .in_vld(in_vld), .out_data(out_data), .out_vld(out_vld),
        .axi_rd_en(axi_rd_en), .axi_rd_addr(axi_rd_addr), .axi_rd_data(axi_rd_data),
        .axi_rd_vld(axi_rd_vld), .axi_wr_en(axi_wr_en), .axi_wr_addr(axi_wr_addr),
        .axi_wr_data(axi_wr_data), .wr_err(wr_err), .frozen(frozen), .wr_ptr(wr_ptr),
        .trig_ptr(trig_ptr), .wrapped(wrapped)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int          e;
        int          w;
        logic [31:0] exp;
    } rdvec_t;

    rdvec_t       tbl [8];
    logic [127:0] mm [DEP];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [95:0] samp(input logic [31:0] v);
        return {v + 32'h0000C000, v + 32'h0000B000, v};
    endfunction

    function automatic logic [95:0] pbe(input int e);
        return {32'(192 + e), 32'(176 + e), 32'(160 + e)};
    endfunction

    // Returns {valid-timing-ok, data}: valid must be low one cycle after the
    // request and high two cycles after it.
    task automatic axi_rd(input int e, input int w, output logic [32:0] res);
        logic ok;
        axi_rd_addr = {4'(e), 2'(w)};
        axi_rd_en   = 1'b1;
        tick();
        axi_rd_en   = 1'b0;
        ok = (axi_rd_vld == 1'b0);
        tick();
        ok = ok & axi_rd_vld;
        res = {ok, axi_rd_data};
    endtask

    task automatic axi_wr(input int e, input int w, input logic [31:0] d);
        axi_wr_addr = {4'(e), 2'(w)};
        axi_wr_data = d;
        axi_wr_en   = 1'b1;
        tick();
        axi_wr_en   = 1'b0;
    endtask

    // One-shot playback of four entries: valid on ticks 2..5 only
    task automatic pb_once(input string nm);
        for (int t = 1; t <= 8; t++) begin
            tick();
            rearm = 1'b0;
            chk({nm, "_vld"}, 128'(out_vld), 128'((t >= 2 && t <= 5) ? 1 : 0));
            if (t >= 2 && t <= 5) chk({nm, "_data"}, 128'(out_data), 128'(pbe(t - 2)));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [32:0] r;
        int          nv;
        int          cnt;
        int          target;
        tbl[0] = '{3, 0, 32'd19};
        tbl[1] = '{3, 1, 32'h0000B013};
        tbl[2] = '{3, 2, 32'h0000C013};
        tbl[3] = '{3, 3, 32'h0};
        tbl[4] = '{4, 0, 32'd4};
        tbl[5] = '{15, 2, 32'h0000C00F};
        tbl[6] = '{0, 0, 32'd16};
        tbl[7] = '{0, 1, 32'h0000B010};

        // Reset values
        repeat (3) tick();
        chk("rst_wr_ptr", 128'(wr_ptr), 128'(0));
        chk("rst_outs", 128'({frozen, wrapped, out_vld, axi_rd_vld, wr_err}), 128'(0));
        chk("rst_trig_ptr", 128'(trig_ptr), 128'(0));
        chk("rst_out_data", 128'(out_data), 128'(0));
        rst = 1'b0;
        tick();

        // Free-run spy: 20 samples into 16 entries
        for (int i = 0; i < 20; i++) begin
            in_vld  = 1'b1;
            in_data = samp(32'(i));
            tick();
            if (i == 14) chk("wrapped_pre", 128'(wrapped), 128'(0));
            if (i == 15) chk("wrapped_set", 128'(wrapped), 128'(1));
        end
        in_vld = 1'b0;
        chk("spy_wr_ptr", 128'(wr_ptr), 128'(4));
        chk("spy_wrapped", 128'(wrapped), 128'(1));
        for (int k = 0; k < 8; k++) begin
            axi_rd(tbl[k].e, tbl[k].w, r);
            chk($sformatf("tbl_rd_e%0d_w%0d", tbl[k].e, tbl[k].w), 128'(r), 128'({1'b1, tbl[k].exp}));
        end

        // Writes rejected while capturing; freeze blocks same-cycle sample
        axi_wr(5, 0, 32'hDEADBEEF);
        chk("wr_err_pulse", 128'(wr_err), 128'(1));
        tick();
        chk("wr_err_clear", 128'(wr_err), 128'(0));
        axi_rd(5, 0, r);
        chk("wr_rejected_mem", 128'(r), 128'({1'b1, 32'd5}));
        freeze = 1'b1; in_vld = 1'b1; in_data = samp(32'h77);
        tick();
        freeze = 1'b0; in_vld = 1'b0;
        chk("freeze_frozen", 128'(frozen), 128'(1));
        chk("freeze_wr_ptr", 128'(wr_ptr), 128'(4));
        axi_rd(4, 0, r);
        chk("freeze_no_store", 128'(r), 128'({1'b1, 32'd4}));
        freeze = 1'b1; rearm = 1'b1;
        tick();
        freeze = 1'b0; rearm = 1'b0;
        chk("rearm_ignored", 128'(frozen), 128'(1));
        rearm = 1'b1;
        tick();
        rearm = 1'b0;
        chk("rearm_state", 128'({frozen, wrapped, wr_ptr}), 128'(0));

        // Trigger-and-freeze with three post-trigger samples
        pb_mode = 2'b01; post_trig_cnt = 4'd3;
        for (int i = 0; i < 11; i++) begin
            in_vld  = 1'b1;
            in_data = samp(32'h100 + 32'(i));
            trigger = (i == 5);
            tick();
            if (i == 7) chk("post_not_frozen", 128'(frozen), 128'(1'b0));
            if (i == 8) chk("post_frozen", 128'(frozen), 128'(1'b1));
        end
        in_vld = 1'b0; trigger = 1'b0;
        chk("trig_ptr", 128'(trig_ptr), 128'(5));
        chk("trig_wr_ptr", 128'(wr_ptr), 128'(9));
        axi_rd(8, 0, r);
        chk("trig_last_sample", 128'(r), 128'({1'b1, 32'h108}));
        axi_rd(9, 0, r);
        chk("trig_no_extra", 128'(r), 128'({1'b1, 32'd9}));
        rearm = 1'b1;
        tick();
        rearm = 1'b0;
        chk("trig_rearm", 128'({frozen, wrapped, wr_ptr}), 128'(0));

        // Trigger with zero post count
        post_trig_cnt = '0;
        in_vld = 1'b1; in_data = samp(32'h2AA); trigger = 1'b1;
        tick();
        trigger = 1'b0; in_data = samp(32'h2BB);
        chk("post0_frozen", 128'(frozen), 128'(1));
        chk("post0_ptrs", 128'({wr_ptr, trig_ptr}), 128'({4'd1, 4'd0}));
        tick();
        in_vld = 1'b0;
        chk("post0_hold", 128'(wr_ptr), 128'(1));
        axi_rd(0, 0, r);
        chk("post0_sample", 128'(r), 128'({1'b1, 32'h2AA}));
        axi_rd(1, 0, r);
        chk("post0_no_next", 128'(r), 128'({1'b1, 32'h101}));

        // Load playback data while frozen
        for (int e = 0; e < 4; e++) begin
            axi_wr(e, 0, 32'(160 + e));
            chk("frozen_wr_ok", 128'(wr_err), 128'(0));
            axi_wr(e, 1, 32'(176 + e));
            axi_wr(e, 2, 32'(192 + e));
        end
        axi_wr(0, 3, 32'hFFFFFFFF);
        axi_rd(0, 3, r);
        chk("pad_word_zero", 128'(r), 128'({1'b1, 32'h0}));

        // One-shot playback, then replay via rearm
        pb_len = 5'd4; pb_mode = 2'b10;
        pb_once("pb10");
        rearm = 1'b1;
        pb_once("pb10_rearm");

        // Looped playback with a two-cycle freeze
        pb_mode = 2'b11; rearm = 1'b1;
        nv = 0;
        for (int t = 1; t <= 16; t++) begin
            freeze = (t == 7 || t == 8);
            tick();
            rearm = 1'b0;
            if (t == 7) chk("loop_freeze_vld", 128'(out_vld), 128'(0));
            if (out_vld) begin
                chk($sformatf("loop_data_%0d", nv), 128'(out_data), 128'(pbe(nv % 4)));
                nv++;
            end
        end
        freeze = 1'b0;
        chk("loop_count", 128'(nv), 128'(13));

        // Reset in the middle of playback
        rst = 1'b1; pb_mode = 2'b00;
        tick();
        chk("midrst_outs", 128'({out_vld, frozen, wr_ptr}), 128'(0));
        rst = 1'b0;
        tick();
        chk("midrst_idle", 128'(out_vld), 128'(0));
        axi_wr(7, 0, 32'h55);
        chk("midrst_spy", 128'(wr_err), 128'(1));
        axi_rd(2, 0, r);
        chk("midrst_keep0", 128'(r), 128'({1'b1, 32'd162}));
        axi_rd(2, 2, r);
        chk("midrst_keep2", 128'(r), 128'({1'b1, 32'd194}));

        // Randomised capture, random AXI loads and readback against a model
        cnt = 0;
        target = 16 + int'($urandom_range(0, 20));
        for (int k = 0; k < 300 && cnt < target; k++) begin
            logic        v;
            logic [95:0] d;
            v = ($urandom_range(0, 3) != 0);
            d = {$urandom, $urandom, $urandom};
            in_vld = v; in_data = d;
            tick();
            if (v) begin
                mm[cnt % DEP] = {32'h0, d};
                cnt++;
            end
        end
        in_vld = 1'b0;
        chk("rnd_wr_ptr", 128'(wr_ptr), 128'(cnt % DEP));
        chk("rnd_wrapped", 128'(wrapped), 128'(cnt >= DEP ? 1 : 0));
        freeze = 1'b1;
        tick();
        freeze = 1'b0;
        chk("rnd_frozen", 128'(frozen), 128'(1));
        for (int k = 0; k < 12; k++) begin
            int          e, w;
            logic [31:0] d;
            e = int'($urandom_range(0, DEP - 1));
            w = int'($urandom_range(0, 3));
            d = $urandom;
            axi_wr(e, w, d);
            if (w < 3) mm[e][w*32 +: 32] = d;
        end
        for (int k = 0; k < 16; k++) begin
            int e, w;
            e = int'($urandom_range(0, DEP - 1));
            w = int'($urandom_range(0, 3));
            axi_rd(e, w, r);
            chk($sformatf("rnd_rd_e%0d_w%0d", e, w), 128'(r), 128'({1'b1, mm[e][w*32 +: 32]}));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
